// File: rtl/filter_out_stage.sv
// Output stage for the IIR core: Q32.32 -> Q16.16 round/saturate, then a FWFT FIFO.
// Optional saturation event counter enabled by defining FILTER_OUT_SATCNT_EN.
module filter_out_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       v_in,
  input  logic              v_valid,
  output logic              v_ready,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag
`ifdef FILTER_OUT_SATCNT_EN
  ,
  output logic [CNT_W-1:0]  sat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [64:0]    r;
  logic           ovf;
  logic [31:0]    conv;
  logic           unused_low;
  logic           accept;

  logic           pipe_valid;
  logic [31:0]    pipe_data;
  logic           pipe_sat;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW+1:0]  occ;
  logic           push;
  logic           pop;

  // Adding 0x8000 before truncation gives round-half-up at bit 15; the
  // 65-bit width keeps the carry out of the most positive input.
  assign r          = {v_in[63], v_in} + 65'h8000;
  assign ovf        = !((&r[64:47]) || !(|r[64:47]));
  assign unused_low = ^r[15:0];

  always_comb begin
    conv = r[47:16];
    if (ovf) conv = r[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Pipe and FIFO both count toward occupancy so an accepted sample always has a slot.
  assign occ       = {1'b0, count} + {{(AW+1){1'b0}}, pipe_valid};
  assign v_ready   = occ < (AW+2)'(DEPTH);
  assign accept    = v_valid && v_ready;
  assign push      = pipe_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      pipe_sat   <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        pipe_data <= conv;
        pipe_sat  <= ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pipe_data;
        wr_ptr      <= wr_ptr + 1'b1;
        if (pipe_sat) sat_flag <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FILTER_OUT_SATCNT_EN
  // Counts saturated samples entering the FIFO; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (push && pipe_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
